// File: rtl/encoder_sched.sv
// ---------------------------------------------------------------------------
// encoder_sched
//
// Round/stage scheduler for a five-stage permutation encoder. Each encode
// runs NROUNDS rounds. Every round issues the stages in a fixed order:
// colparity, rotate, permute, revaluate, addrc. Each stage uses a
// start/ready handshake. The state memory is ping-ponged once per completed
// stage.
//
// Optional feature: define ENC_TIMEOUT_EN to add a per-stage watchdog
// (parameter TO_CYCLES) that drives the sticky err flag. When the macro is
// not defined, there is no watchdog and err is tied low.
//
// Parameters
//   NROUNDS    rounds per encode, 1..31
//   TO_CYCLES  watchdog limit per stage (only with ENC_TIMEOUT_EN)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      encode request; acted on only in IDLE/ARM
//   abort      synchronous cancel of a running encode
//   stg_ready  per-stage ready, bit 0 colparity .. bit 4 addrc
//   stg_start  one-hot stage start, same bit order
//   round      current round index (addrc constant select)
//   stage      index of the active stage, 0..4
//   mem_sel    stage reads bank mem_sel and writes bank ~mem_sel
//   ready      high only while idle
//   done       one-cycle pulse after the last stage of the last round
//   err        sticky watchdog flag
// ---------------------------------------------------------------------------
module encoder_sched #(
  parameter int unsigned NROUNDS = 24
`ifdef ENC_TIMEOUT_EN
  , parameter int unsigned TO_CYCLES = 4095
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] stg_ready,
  output logic [4:0] stg_start,
  output logic [4:0] round,
  output logic [2:0] stage,
  output logic       mem_sel,
  output logic       ready,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT,
    NEXT,
    FIN
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NROUNDS - 1);
  localparam logic [2:0] LAST_STAGE = 3'd4;

  state_t     state;
  logic [4:0] stage_mask;
  logic       cur_ready;
  logic       wdog_hit;

  // Only the ready bit of the active stage is looked at.
  always_comb begin
    stage_mask = 5'b00001 << stage;
    cur_ready  = |(stg_ready & stage_mask);
  end

`ifdef ENC_TIMEOUT_EN
  localparam logic [11:0] TO_LIM = 12'(TO_CYCLES);

  logic [11:0] wdog;
  logic        err_q;

  // The count is held at zero outside ISSUE/WAIT, so it is already clear on
  // every entry to ISSUE. It saturates at the limit. err is raised when the
  // count reaches the limit; the FSM falls back to IDLE on the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (state == ISSUE || state == WAIT) begin
      if (wdog != TO_LIM) begin
        wdog <= wdog + 12'd1;
      end
      if ((wdog + 12'd1) == TO_LIM && !abort) begin
        err_q <= 1'b1;
      end
    end else begin
      wdog <= '0;
      if (state == IDLE && start) begin
        err_q <= 1'b0;
      end
    end
  end

  assign wdog_hit = (state == ISSUE || state == WAIT) && (wdog == TO_LIM);
  assign err      = err_q;
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stg_start <= '0;
      round     <= '0;
      stage     <= '0;
      mem_sel   <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort and watchdog expiry take priority over any pending NEXT/FIN
      // work. round/stage/mem_sel are left as they are and are cleared by
      // the next start.
      if ((abort && state != IDLE) || wdog_hit) begin
        state     <= IDLE;
        stg_start <= '0;
        ready     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= ARM;
              ready   <= 1'b0;
              round   <= '0;
              stage   <= '0;
              mem_sel <= 1'b0;
            end
          end
          ARM: begin
            if (!start) begin
              state     <= ISSUE;
              stg_start <= stage_mask;
            end
          end
          ISSUE: begin
            if (!cur_ready) begin
              state     <= WAIT;
              stg_start <= '0;
            end
          end
          WAIT: begin
            if (cur_ready) begin
              state <= NEXT;
            end
          end
          NEXT: begin
            mem_sel <= ~mem_sel;
            if (stage != LAST_STAGE) begin
              stage     <= stage + 3'd1;
              stg_start <= stage_mask << 1;
              state     <= ISSUE;
            end else if (round != LAST_ROUND) begin
              stage     <= '0;
              round     <= round + 5'd1;
              stg_start <= 5'b00001;
              state     <= ISSUE;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
          FIN: begin
            state <= IDLE;
            ready <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            stg_start <= '0;
            ready     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/encoder_sched.md
ENCODER_SCHED -- requirements
Module: encoder_sched

Interface
REQ-001 Parameter NROUNDS, default 24: rounds per encode; legal range 1..31.
REQ-002 Parameter TO_CYCLES, default 4095: watchdog limit per stage; present only with ENC_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  encode request from host.
REQ-006 abort  input  1  synchronous cancel of the running encode.
REQ-007 stg_ready  input  5  per-stage ready; bit 0 colparity, 1 rotate, 2 permute, 3 revaluate, 4 addrc.
REQ-008 stg_start  output  5  one-hot stage start, same bit order.
REQ-009 round  output  5  current round index, 0..NROUNDS-1, drives addrc constant select.
REQ-010 stage  output  3  index of active stage, 0..4.
REQ-011 mem_sel  output  1  ping-pong state-memory select; stage reads bank mem_sel, writes bank ~mem_sel.
REQ-012 ready  output  1  high only in IDLE.
REQ-013 done  output  1  one-cycle pulse when the final stage of the final round completes.
REQ-014 err  output  1  sticky watchdog flag; tied 0 without ENC_TIMEOUT_EN.

Function
REQ-015 States: IDLE, ARM, ISSUE, WAIT, NEXT, FIN.
REQ-016 IDLE: ready=1; start=1 -> ARM; round, stage and mem_sel cleared to 0 on that transition.
REQ-017 ARM: wait for start=0, then -> ISSUE; start held high keeps ARM.
REQ-018 ISSUE: stg_start[stage]=1, all other bits 0; stays until stg_ready[stage]=0, then -> WAIT.
REQ-019 WAIT: stg_start=0; stays until stg_ready[stage]=1, then -> NEXT.
REQ-020 NEXT (one cycle): mem_sel toggles; if stage<4, stage+1 -> ISSUE; if stage=4 and round<NROUNDS-1, stage=0, round+1 -> ISSUE; if stage=4 and round=NROUNDS-1 -> FIN.
REQ-021 FIN (one cycle): done=1 -> IDLE; round and stage hold final values until next start.
REQ-022 Latency: start fall to first stg_start = 1 cycle; stage complete (stg_ready rise) to next stg_start = 2 cycles.
REQ-023 stg_start never has more than one bit set; stg_ready bits of non-active stages ignored.
REQ-024 start outside IDLE/ARM ignored.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, stg_start=0, done not pulsed; abort wins over simultaneous NEXT/FIN.
REQ-026 abort in IDLE has no effect.
REQ-027 round width 5; no wrap beyond NROUNDS-1.

Reset
REQ-028 rst_n=0 forces IDLE immediately: stg_start=0, round=0, stage=0, mem_sel=0, done=0, err=0, ready=1 once reset state is entered.
REQ-029 Reset mid-encode discards progress; no done pulse; first start after release begins at round 0.

Configuration
REQ-030 Macro ENC_TIMEOUT_EN defined: 12-bit watchdog clears on entering ISSUE and counts each cycle in ISSUE/WAIT.
REQ-031 With ENC_TIMEOUT_EN, count reaching TO_CYCLES sets err and returns to IDLE next cycle with stg_start=0.
REQ-032 With ENC_TIMEOUT_EN, err clears only on reset or on the next accepted start.
REQ-033 Without ENC_TIMEOUT_EN: no watchdog logic, err tied 0, ISSUE/WAIT wait indefinitely.

Verification
REQ-034 NROUNDS=2, model stages each drop ready 1 cycle after start and raise it 3 cycles later -> stg_start sequence 1,2,4,8,16 per round, round 0 then 1, 10 stage starts, single done pulse, mem_sel toggles 10 times ending 0.
REQ-035 start held high 5 cycles -> stays ARM; first stg_start=5'b00001 exactly 1 cycle after start falls.
REQ-036 abort asserted in WAIT of round 1 stage 2 -> IDLE next cycle, stg_start=0, done stays 0; next start begins at round 0, stage 0.
REQ-037 rst_n pulsed low during round 5 ISSUE -> outputs at reset values asynchronously; no done.
REQ-038 ENC_TIMEOUT_EN, TO_CYCLES=16, stage 3 never drops ready -> err=1 after 16 cycles in ISSUE, IDLE next cycle; err clears on next start.
